// File: rtl/vga_pkg.sv
// Shared VGA constants, the RGB444 pixel type and the built-in sprite pattern.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int RGB_W = 12;
  typedef logic [RGB_W-1:0] rgb_t;

  localparam rgb_t DEF_BG_COLOR  = 12'h8CF;
  localparam rgb_t DEF_KEY_COLOR = 12'hF0F;

  // Sprite texel for a given animation frame, row and column.
  // Frame 0 is solid green; every later frame is tinted by its index in the
  // red nibble and has a transparent top-left texel.
  function automatic rgb_t spriteTexel(input int frame, input int row, input int col);
    rgb_t texel;
    if (frame == 0) begin
      texel = 12'h0F0;
    end else if ((row == 0) && (col == 0)) begin
      texel = DEF_KEY_COLOR;
    end else begin
      texel = {frame[3:0], 8'h42};
    end
    return texel;
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Synchronous-read sprite ROM, one cycle of latency, 12-bit RGB444 texels.
// The address is {frame, row, column}; contents come from the package pattern.
module sprite_rom
  import vga_pkg::*;
#(
  parameter int XW = 5,
  parameter int YW = 5,
  parameter int FW = 2,
  parameter int AW = FW + YW + XW
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr,
  output rgb_t          o_data
);

  logic [XW-1:0] w_col;
  logic [YW-1:0] w_row;
  logic [FW-1:0] w_frame;
  rgb_t          r_data;

  assign w_col   = i_addr[XW-1:0];
  assign w_row   = i_addr[XW +: YW];
  assign w_frame = i_addr[AW-1 -: FW];

  // Registered read: data for an address appears one clock later.
  always_ff @(posedge clk) begin
    r_data <= spriteTexel(int'(w_frame), int'(w_row), int'(w_col));
  end

  assign o_data = r_data;

endmodule

// File: rtl/pig_sprite_render.sv
// Pixel stage after the VGA timing generator: draws an animated, colour-keyed
// sprite over a flat background with a 2-clock RGB pipeline and matching syncs.
module pig_sprite_render
  import vga_pkg::*;
#(
  parameter int   SPR_W     = 32,
  parameter int   SPR_H     = 32,
  parameter int   N_FRAMES  = 4,
  parameter int   FRAME_DIV = 6,
  parameter rgb_t BG_COLOR  = DEF_BG_COLOR,
  parameter rgb_t KEY_COLOR = DEF_KEY_COLOR
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic       anim_en,
  output logic [11:0] rgb,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int XW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int YW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int FW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int AW = FW + YW + XW;

  // Shadow position, animation state and latch pulse
  logic [9:0]    r_sx;
  logic [9:0]    r_sy;
  logic [FW-1:0] r_animIdx;
  logic [DW-1:0] r_div;
  logic          r_frameTick;

  // Pipeline registers
  logic r_videoOn1;
  logic r_inSpr1;
  logic r_hsync1;
  logic r_vsync1;
  rgb_t r_rgb;
  logic r_hsync2;
  logic r_vsync2;

  // Combinational helpers
  logic          w_latch;
  logic [10:0]   w_px;
  logic [10:0]   w_py;
  logic [10:0]   w_xLo;
  logic [10:0]   w_xHi;
  logic [10:0]   w_yLo;
  logic [10:0]   w_yHi;
  logic          w_inSpr;
  logic [XW-1:0] w_dx;
  logic [YW-1:0] w_dy;
  logic [AW-1:0] w_addr;
  rgb_t          w_romData;

  // The first pixel of the first blanking line is the only moment the
  // shadow position and animation state may change.
  assign w_latch = (pixel_x == 10'd0) && (pixel_y == 10'(V_ACTIVE));

  // Bounds are compared in 11 bits so a sprite near the right or bottom
  // edge clips instead of wrapping around to column or row 0.
  assign w_px    = {1'b0, pixel_x};
  assign w_py    = {1'b0, pixel_y};
  assign w_xLo   = {1'b0, r_sx};
  assign w_yLo   = {1'b0, r_sy};
  assign w_xHi   = w_xLo + 11'(SPR_W);
  assign w_yHi   = w_yLo + 11'(SPR_H);
  assign w_inSpr = (w_px >= w_xLo) && (w_px < w_xHi) &&
                   (w_py >= w_yLo) && (w_py < w_yHi);

  // Only the low bits of the sprite-relative offsets address the ROM; the
  // low bits of a difference equal the difference of the low bits.
  assign w_dx   = pixel_x[XW-1:0] - r_sx[XW-1:0];
  assign w_dy   = pixel_y[YW-1:0] - r_sy[YW-1:0];
  assign w_addr = {r_animIdx, w_dy, w_dx};

  // Capture position, pulse frame_tick and step the animation divider at each latch.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_sx        <= '0;
      r_sy        <= '0;
      r_animIdx   <= '0;
      r_div       <= '0;
      r_frameTick <= 1'b0;
    end else begin
      r_frameTick <= w_latch;
      if (w_latch) begin
        r_sx <= pos_x;
        r_sy <= pos_y;
        if (r_div == DW'(FRAME_DIV - 1)) begin
          r_div <= '0;
          if (anim_en && (N_FRAMES > 1)) begin
            r_animIdx <= r_animIdx + FW'(1);
          end
        end else begin
          r_div <= r_div + DW'(1);
        end
      end
    end
  end

  // The ROM register forms the data half of stage 1.
  sprite_rom #(
    .XW(XW),
    .YW(YW),
    .FW(FW),
    .AW(AW)
  ) u_spriteRom (
    .clk   (clk),
    .i_addr(w_addr),
    .o_data(w_romData)
  );

  // Stage 1: register the flags that travel alongside the ROM read.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_videoOn1 <= 1'b0;
      r_inSpr1   <= 1'b0;
      r_hsync1   <= 1'b0;
      r_vsync1   <= 1'b0;
    end else begin
      r_videoOn1 <= video_on;
      r_inSpr1   <= w_inSpr;
      r_hsync1   <= hsync_in;
      r_vsync1   <= vsync_in;
    end
  end

  // Stage 2: pick blank, background/transparent or sprite colour and align syncs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_rgb    <= '0;
      r_hsync2 <= 1'b0;
      r_vsync2 <= 1'b0;
    end else begin
      r_hsync2 <= r_hsync1;
      r_vsync2 <= r_vsync1;
      if (!r_videoOn1) begin
        r_rgb <= '0;
      end else if (!r_inSpr1 || (w_romData == KEY_COLOR)) begin
        r_rgb <= BG_COLOR;
      end else begin
        r_rgb <= w_romData;
      end
    end
  end

  assign rgb        = r_rgb;
  assign hsync      = r_hsync2;
  assign vsync      = r_vsync2;
  assign frame_tick = r_frameTick;

endmodule

// File: tb/tb_pig_sprite_render.sv
// Directed bench for pig_sprite_render: drives pixel coordinates directly
// (jumping to the latch coordinate) and checks hand-computed colours.
module tb_pig_sprite_render;

  localparam logic [11:0] BG    = 12'h8CF;
  localparam logic [11:0] GREEN = 12'h0F0;
  localparam logic [11:0] F1    = 12'h142;
  localparam logic [11:0] F2    = 12'h242;
  localparam logic [11:0] F3    = 12'h342;

  logic        clk;
  logic        clr;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        anim_en;
  logic [11:0] rgb;
  logic        hsync;
  logic        vsync;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  pig_sprite_render dut (
    .clk       (clk),
    .clr       (clr),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .video_on  (video_on),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .anim_en   (anim_en),
    .rgb       (rgb),
    .hsync     (hsync),
    .vsync     (vsync),
    .frame_tick(frame_tick)
  );

  // 10 ns pixel clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel's worth of timing-generator inputs for one clock.
  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y,
                               input logic von, input logic hs, input logic vs);
    pixel_x  = x;
    pixel_y  = y;
    video_on = von;
    hsync_in = hs;
    vsync_in = vs;
    step();
  endtask

  task automatic checkOutput(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one pixel, then a blanked filler pixel, and check the colour
  // that emerges two clocks after the pixel was presented.
  task automatic checkPixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                            input logic von, input logic [11:0] exp);
    applyStimulus(x, y, von, 1'b0, 1'b0);
    applyStimulus(10'd700, 10'd10, 1'b0, 1'b0, 1'b0);
    checkOutput(tag, rgb, exp);
  endtask

  // Present a new position together with the latch coordinate and check
  // that frame_tick is high for exactly the following cycle.
  task automatic doLatch(input logic [9:0] px, input logic [9:0] py, input string tag);
    pos_x = px;
    pos_y = py;
    applyStimulus(10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, " tick"}, 12'(frame_tick), 12'd1);
    applyStimulus(10'd700, 10'd10, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, " tick off"}, 12'(frame_tick), 12'd0);
  endtask

  initial begin
    clr      = 1'b1;
    pixel_x  = 10'd700;
    pixel_y  = 10'd10;
    video_on = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    pos_x    = 10'd0;
    pos_y    = 10'd0;
    anim_en  = 1'b0;
    step();
    step();
    checkOutput("reset rgb", rgb, 12'h000);
    checkOutput("reset hsync", 12'(hsync), 12'd0);
    checkOutput("reset vsync", 12'(vsync), 12'd0);
    checkOutput("reset tick", 12'(frame_tick), 12'd0);
    clr = 1'b0;

    // Before any latch the sprite sits at (0,0) showing frame 0
    checkPixel("prelatch 5,5", 10'd5, 10'd5, 1'b1, GREEN);
    checkPixel("prelatch 0,0", 10'd0, 10'd0, 1'b1, GREEN);
    checkPixel("prelatch 31,31", 10'd31, 10'd31, 1'b1, GREEN);
    checkPixel("prelatch 32,0", 10'd32, 10'd0, 1'b1, BG);
    checkPixel("blank 5,5", 10'd5, 10'd5, 1'b0, 12'h000);

    // Sprite at (100,50): covers x 100..131, y 50..81
    doLatch(10'd100, 10'd50, "latch 100,50");
    checkPixel("p 100,50", 10'd100, 10'd50, 1'b1, GREEN);
    checkPixel("p 131,81", 10'd131, 10'd81, 1'b1, GREEN);
    checkPixel("p 99,50", 10'd99, 10'd50, 1'b1, BG);
    checkPixel("p 132,50", 10'd132, 10'd50, 1'b1, BG);
    checkPixel("p 100,49", 10'd100, 10'd49, 1'b1, BG);
    checkPixel("p 100,82", 10'd100, 10'd82, 1'b1, BG);

    // Sync outputs lag their inputs by exactly two clocks
    applyStimulus(10'd700, 10'd10, 1'b0, 1'b1, 1'b0);
    checkOutput("hsync lag1", 12'(hsync), 12'd0);
    applyStimulus(10'd700, 10'd10, 1'b0, 1'b0, 1'b1);
    checkOutput("hsync lag2", 12'(hsync), 12'd1);
    checkOutput("vsync lag1", 12'(vsync), 12'd0);
    applyStimulus(10'd700, 10'd10, 1'b0, 1'b0, 1'b0);
    checkOutput("hsync lag3", 12'(hsync), 12'd0);
    checkOutput("vsync lag2", 12'(vsync), 12'd1);

    // Mid-frame position change is ignored until the next latch
    pos_x = 10'd300;
    checkPixel("midframe old x", 10'd100, 10'd60, 1'b1, GREEN);
    checkPixel("midframe new x", 10'd300, 10'd60, 1'b1, BG);
    doLatch(10'd300, 10'd50, "latch 300,50");
    checkPixel("nextframe new x", 10'd300, 10'd60, 1'b1, GREEN);
    checkPixel("nextframe old x", 10'd100, 10'd60, 1'b1, BG);
    checkPixel("nextframe 331,81", 10'd331, 10'd81, 1'b1, GREEN);

    // Clipped at the bottom-right corner, no wrap to row/column 0
    doLatch(10'd620, 10'd470, "latch 620,470");
    checkPixel("clip 620,470", 10'd620, 10'd470, 1'b1, GREEN);
    checkPixel("clip 639,479", 10'd639, 10'd479, 1'b1, GREEN);
    checkPixel("clip 619,470", 10'd619, 10'd470, 1'b1, BG);
    checkPixel("nowrap 4,470", 10'd4, 10'd470, 1'b1, BG);
    checkPixel("nowrap 620,4", 10'd620, 10'd4, 1'b1, BG);
    checkPixel("clip blank 645,475", 10'd645, 10'd475, 1'b0, 12'h000);

    // Sprite entirely right of the active area is invisible
    doLatch(10'd700, 10'd20, "latch 700,20");
    checkPixel("offscreen 639,20", 10'd639, 10'd20, 1'b1, BG);
    checkPixel("offscreen 20,20", 10'd20, 10'd20, 1'b1, BG);

    // Asynchronous reset mid-line while the sprite is on screen
    doLatch(10'd8, 10'd8, "latch 8,8");
    applyStimulus(10'd10, 10'd10, 1'b1, 1'b1, 1'b1);
    applyStimulus(10'd10, 10'd10, 1'b1, 1'b1, 1'b1);
    checkOutput("pre-clr rgb", rgb, GREEN);
    checkOutput("pre-clr hsync", 12'(hsync), 12'd1);
    clr = 1'b1;
    #1;
    checkOutput("clr rgb", rgb, 12'h000);
    checkOutput("clr hsync", 12'(hsync), 12'd0);
    checkOutput("clr vsync", 12'(vsync), 12'd0);
    checkOutput("clr tick", 12'(frame_tick), 12'd0);
    step();
    clr = 1'b0;

    // Reset returned the shadow position to (0,0)
    anim_en = 1'b1;
    checkPixel("postclr 2,2", 10'd2, 10'd2, 1'b1, GREEN);
    checkPixel("postclr 35,10", 10'd35, 10'd10, 1'b1, BG);
    pos_x = 10'd0;
    pos_y = 10'd0;
    applyStimulus(10'd0, 10'd479, 1'b0, 1'b0, 1'b0);
    checkOutput("no tick at 479", 12'(frame_tick), 12'd0);

    // Animation: one step every 6 latches, frame index wraps after 4 steps
    doLatch(10'd0, 10'd0, "anim latch 1");
    for (int n = 2; n <= 24; n++) begin
      doLatch(10'd0, 10'd0, $sformatf("anim latch %0d", n));
      if (n == 5) checkPixel("anim 5 frame0", 10'd1, 10'd1, 1'b1, GREEN);
      if (n == 6) begin
        checkPixel("anim 6 frame1", 10'd1, 10'd1, 1'b1, F1);
        checkPixel("anim 6 key texel", 10'd0, 10'd0, 1'b1, BG);
      end
      if (n == 12) checkPixel("anim 12 frame2", 10'd1, 10'd1, 1'b1, F2);
      if (n == 18) checkPixel("anim 18 frame3", 10'd1, 10'd1, 1'b1, F3);
      if (n == 24) begin
        checkPixel("anim 24 frame0", 10'd1, 10'd1, 1'b1, GREEN);
        checkPixel("anim 24 corner", 10'd0, 10'd0, 1'b1, GREEN);
      end
    end
    for (int n = 25; n <= 30; n++) doLatch(10'd0, 10'd0, $sformatf("anim latch %0d", n));
    checkPixel("anim 30 frame1", 10'd1, 10'd1, 1'b1, F1);

    // Disabled animation holds the frame while the divider keeps counting
    anim_en = 1'b0;
    for (int n = 0; n < 3; n++) doLatch(10'd0, 10'd0, $sformatf("hold latch %0d", n));
    checkPixel("hold frame1", 10'd1, 10'd1, 1'b1, F1);
    anim_en = 1'b1;
    for (int n = 0; n < 3; n++) doLatch(10'd0, 10'd0, $sformatf("resume latch %0d", n));
    checkPixel("resume frame2", 10'd1, 10'd1, 1'b1, F2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
